// File: rtl/imm_pkg.sv
// imm_pkg -- shared definitions for the immediate-decode stage.
//   imm_fmt_e    : immediate format code presented on out_fmt
//   OPC_*        : RV32/RV64 base opcodes recognised by the decoder
//   xlen_legal   : elaboration-time check of the datapath width
//   depth_legal  : elaboration-time check of the output buffer depth
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth == 1) || (depth == 2);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode -- purely combinational immediate decoder.
//   inst    : 32-bit base instruction word
//   pc      : instruction address (XLEN)
//   imm     : sign-/zero-extended immediate (XLEN)
//   fmt     : immediate format code
//   target  : pc + imm for B, J and AUIPC, otherwise 0 (wraps modulo 2^XLEN)
//   illegal : encoding not supported by this stage
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;      // immediate built at 32 bits, sign-extended afterwards
    logic        is_shamt;
    logic        use_target;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    always_comb begin
        imm32      = 32'd0;
        fmt        = FMT_NONE;
        illegal    = 1'b0;
        is_shamt   = 1'b0;
        use_target = 1'b0;
        // Every listed opcode ends in 2'b11, so compressed encodings
        // (inst[1:0] != 2'b11) always land in the default arm.
        case (opcode)
            OPC_OP_IMM: begin
                if ((funct3 == F3_SLLI) || (funct3 == F3_SRXI)) begin
                    fmt      = FMT_SHAMT;
                    is_shamt = 1'b1;
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                fmt        = FMT_B;
                imm32      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                use_target = 1'b1;
            end
            OPC_LUI: begin
                fmt   = FMT_U;
                imm32 = {inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                fmt        = FMT_U;
                imm32      = {inst[31:12], 12'b0};
                use_target = 1'b1;
            end
            OPC_JAL: begin
                fmt        = FMT_J;
                imm32      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                use_target = 1'b1;
            end
            OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: begin
                fmt = FMT_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Shift amounts are zero-extended; the funct7 bits never leak in.
    // RV64 uses a 6-bit shamt, RV32 a 5-bit one.
    always_comb begin
        if (is_shamt) begin
            if (XLEN == 64) begin
                imm = XLEN'(inst[25:20]);
            end else begin
                imm = XLEN'(inst[24:20]);
            end
        end else begin
            imm = XLEN'($signed(imm32));
        end
    end

    assign target = use_target ? (pc + imm) : '0;

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage -- immediate decoder followed by a small valid/ready
// output buffer (1 or 2 entries). Results appear one cycle after acceptance.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : discard all buffered entries (beats a same-cycle push)
//   in_valid/in_ready : input handshake; in_ready depends on registered count only
//   in_inst, in_pc    : instruction word and its address
//   out_valid/out_ready : output handshake on the head entry
//   out_imm, out_fmt, out_target, out_pc, out_illegal : head entry, 0 when empty
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    generate
        if (!xlen_legal(XLEN) || !depth_legal(DEPTH)) begin : g_bad_param
            $error("imm_decode_stage: XLEN must be 32/64 and DEPTH must be 1/2");
        end
    endgenerate

    localparam int         PW      = 1;
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    // Decoder outputs for the incoming instruction.
    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic [XLEN-1:0] dec_target;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst),
        .pc      (in_pc),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .target  (dec_target),
        .illegal (dec_illegal)
    );

    // Buffer storage and pointers.
    logic [XLEN-1:0] imm_q     [DEPTH];
    logic [2:0]      fmt_q     [DEPTH];
    logic [XLEN-1:0] target_q  [DEPTH];
    logic [XLEN-1:0] pc_q      [DEPTH];
    logic            illegal_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;

    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i]     <= '0;
                fmt_q[i]     <= 3'd0;
                target_q[i]  <= '0;
                pc_q[i]      <= '0;
                illegal_q[i] <= 1'b0;
            end
        end else if (push) begin
            imm_q[tail_q]     <= dec_imm;
            fmt_q[tail_q]     <= dec_fmt;
            target_q[tail_q]  <= dec_target;
            pc_q[tail_q]      <= in_pc;
            illegal_q[tail_q] <= dec_illegal;
        end
    end

    // Stale entries are masked so an empty stage always shows zeros.
    assign out_imm     = out_valid ? imm_q[head_q]     : '0;
    assign out_fmt     = out_valid ? fmt_q[head_q]     : 3'd0;
    assign out_target  = out_valid ? target_q[head_q]  : '0;
    assign out_pc      = out_valid ? pc_q[head_q]      : '0;
    assign out_illegal = out_valid ? illegal_q[head_q] : 1'b0;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;

    // XLEN=32 instance
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_pc, out_imm, out_target, out_pc;
    logic [2:0]  out_fmt;

    // XLEN=64 instance
    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
    logic [31:0] in_inst64;
    logic [63:0] in_pc64, out_imm64, out_target64, out_pc64;
    logic [2:0]  out_fmt64;

    imm_decode_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .in_inst(in_inst64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_target(out_target64),
        .out_pc(out_pc64), .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    vec_t sb [$];
    vec_t cur;
    vec_t e_pop;

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                                input logic [31:0] imm, input int fmt,
                                input logic [31:0] tgt, input logic ill);
        vec_t v;
        v.inst = inst; v.pc = pc; v.imm = imm; v.fmt = 3'(fmt); v.tgt = tgt; v.ill = ill;
        return v;
    endfunction

    // Scoreboard: expected records enter on an accepted push, leave when
    // the consumer takes the head entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready && !flush) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: got pc=%h imm=%h with nothing expected", out_pc, out_imm);
                end else begin
                    e_pop = sb.pop_front();
                    if (out_imm !== e_pop.imm || out_fmt !== e_pop.fmt || out_target !== e_pop.tgt ||
                        out_pc !== e_pop.pc || out_illegal !== e_pop.ill) begin
                        n_bad++;
                        $display("FAIL out inst=%h: got imm=%h fmt=%0d tgt=%h pc=%h ill=%b, want imm=%h fmt=%0d tgt=%h pc=%h ill=%b",
                                 e_pop.inst, out_imm, out_fmt, out_target, out_pc, out_illegal,
                                 e_pop.imm, e_pop.fmt, e_pop.tgt, e_pop.pc, e_pop.ill);
                    end else begin
                        $display("ok  inst=%h pc=%h imm=%h fmt=%0d tgt=%h ill=%b",
                                 e_pop.inst, out_pc, out_imm, out_fmt, out_target, out_illegal);
                    end
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(cur);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end else begin
            $display("ok  %s = %h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        cur      = v;
        in_inst  = v.inst;
        in_pc    = v.pc;
        in_valid = 1'b1;
    endtask

    // Waits (bounded) until the currently driven entry is accepted; returns
    // at #1 after the accepting edge. Reports the number of refused edges.
    task automatic wait_accept(output int stalls);
        logic acc;
        int   budget;
        acc    = 1'b0;
        budget = 0;
        stalls = 0;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_timeout: got no acceptance, want acceptance within 50 cycles");
        end
    endtask

    task automatic push_wait(input vec_t v);
        int s;
        drive(v);
        wait_accept(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        int stalls_total;
        int s;

        vecs[0]  = mk(32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 1, 32'h0, 1'b0); // addi -1
        vecs[1]  = mk(32'h4010D093, 32'h0000_0004, 32'h0000_0001, 6, 32'h0, 1'b0); // srai 1
        vecs[2]  = mk(32'hFE000EE3, 32'h0000_0100, 32'hFFFF_FFFC, 3, 32'h0000_00FC, 1'b0); // beq -4
        vecs[3]  = mk(32'h12345097, 32'h0000_1000, 32'h1234_5000, 4, 32'h1234_6000, 1'b0); // auipc
        vecs[4]  = mk(32'h123450B7, 32'h0000_1004, 32'h1234_5000, 4, 32'h0, 1'b0); // lui
        vecs[5]  = mk(32'h0000_0000, 32'h0000_2000, 32'h0, 0, 32'h0, 1'b1); // all zero
        vecs[6]  = mk(32'hFE20AC23, 32'h0000_2004, 32'hFFFF_FFF8, 2, 32'h0, 1'b0); // sw -8
        vecs[7]  = mk(32'h008000EF, 32'h0000_0200, 32'h0000_0008, 5, 32'h0000_0208, 1'b0); // jal +8
        vecs[8]  = mk(32'h002081B3, 32'h0000_0300, 32'h0, 0, 32'h0, 1'b0); // add
        vecs[9]  = mk(32'hFFFF_FFFF, 32'h0000_0304, 32'h0, 0, 32'h0, 1'b1); // opcode 7F
        vecs[10] = mk(32'h0000_0001, 32'h0000_0308, 32'h0, 0, 32'h0, 1'b1); // compressed
        vecs[11] = mk(32'h03F09093, 32'h0000_030C, 32'h0000_001F, 6, 32'h0, 1'b0); // slli, bit25 set
        vecs[12] = mk(32'h0000_0073, 32'h0000_0310, 32'h0, 0, 32'h0, 1'b0); // ecall
        vecs[13] = mk(32'h00412083, 32'h0000_0314, 32'h0000_0004, 1, 32'h0, 1'b0); // lw 4
        vecs[14] = mk(32'h0000_0463, 32'hFFFF_FFFC, 32'h0000_0008, 3, 32'h0000_0004, 1'b0); // beq +8 wraps
        vecs[15] = mk(32'hFFF080E7, 32'h0000_0400, 32'hFFFF_FFFF, 1, 32'h0, 1'b0); // jalr -1, no target
        vecs[16] = mk(32'h0000_000F, 32'h0000_0404, 32'h0, 0, 32'h0, 1'b0); // fence

        rst_n = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        in_valid64 = 1'b0; in_inst64 = '0; in_pc64 = '0; out_ready64 = 1'b1;
        cur = vecs[0];

        #7;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming: one vector per cycle, consumer always ready.
        stalls_total = 0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            wait_accept(s);
            stalls_total += s;
            if (i == 0) begin
                check("latency_valid", 64'(out_valid), 64'd1);
                check("latency_imm", 64'(out_imm), 64'(vecs[0].imm));
            end
        end
        in_valid = 1'b0;
        tick(); tick();
        check("stream_stalls", 64'(stalls_total), 64'd0);
        check("stream_drained", 64'(sb.size()), 64'd0);

        // Back-pressure: A,B fill the buffer, C waits, A holds steady.
        out_ready = 1'b0;
        push_wait(vecs[0]);
        push_wait(vecs[2]);
        check("full_in_ready", 64'(in_ready), 64'd0);
        drive(vecs[3]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_imm", 64'(out_imm), 64'(vecs[0].imm));
            check("stall_pc", 64'(out_pc), 64'(vecs[0].pc));
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        tick();
        out_ready = 1'b1;
        wait_accept(s);
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("order_drained", 64'(sb.size()), 64'd0);

        // Flush with a full buffer and a pending push.
        out_ready = 1'b0;
        push_wait(vecs[6]);
        push_wait(vecs[7]);
        drive(vecs[4]);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_full_valid", 64'(out_valid), 64'd0);
        check("flush_full_imm", 64'(out_imm), 64'd0);

        // Flush beats a push that would otherwise be accepted.
        push_wait(vecs[13]);
        drive(vecs[14]);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_push_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick(); tick();
        check("flush_stays_empty", 64'(out_valid), 64'd0);

        // XLEN=64 instance.
        in_inst64 = 32'hFFFFF06F; in_pc64 = 64'h0; in_valid64 = 1'b1;
        tick();
        in_valid64 = 1'b0;
        check("x64_jal_valid", 64'(out_valid64), 64'd1);
        check("x64_jal_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFE);
        check("x64_jal_target", out_target64, 64'hFFFF_FFFF_FFFF_FFFE);
        check("x64_jal_fmt", 64'(out_fmt64), 64'd5);
        in_inst64 = 32'h4200D093; in_pc64 = 64'h8; in_valid64 = 1'b1;
        tick();
        in_valid64 = 1'b0;
        check("x64_shamt_imm", out_imm64, 64'h20);
        check("x64_shamt_fmt", 64'(out_fmt64), 64'd6);

        // Reset pulse mid-stream on both instances.
        out_ready = 1'b0;
        out_ready64 = 1'b0;
        push_wait(vecs[1]);
        push_wait(vecs[3]);
        in_valid = 1'b0;
        in_inst64 = 32'h008000EF; in_pc64 = 64'h40; in_valid64 = 1'b1;
        tick();
        in_valid64 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_pc", 64'(out_pc), 64'd0);
        check("async_rst_valid64", 64'(out_valid64), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        out_ready64 = 1'b1;
        tick(); tick(); tick();
        check("after_rst_valid", 64'(out_valid), 64'd0);
        check("after_rst_valid64", 64'(out_valid64), 64'd0);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; legal values 1 and 2.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_valid  input  1  in_inst/in_pc valid.
REQ-008 in_ready  output  1  stage can accept.
REQ-009 in_inst  input  32  RV32/RV64 base instruction word.
REQ-010 in_pc  input  XLEN  instruction address.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  consumer accepts head.
REQ-013 out_imm  output  XLEN  sign-/zero-extended immediate.
REQ-014 out_fmt  output  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6.
REQ-015 out_target  output  XLEN  in_pc + out_imm for B, J, AUIPC; else 0.
REQ-016 out_pc  output  XLEN  in_pc of head entry.
REQ-017 out_illegal  output  1  unsupported encoding.

Function
REQ-018 SHALL decode opcodes: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011/0001111/1110011 -> NONE, imm 0.
REQ-019 I/S/B/J immediates SHALL be sign-extended from inst[31] to XLEN; B and J bit 0 = 0.
REQ-020 U immediate SHALL be {inst[31:12], 12'b0}, sign-extended to XLEN.
REQ-021 Opcode 0010011 with funct3 001 or 101 SHALL give fmt SHAMT, imm zero-extended shamt: inst[24:20] if XLEN=32, inst[25:20] if XLEN=64; funct7 bits excluded.
REQ-022 inst[1:0]!=2'b11 or an unlisted opcode SHALL give out_illegal=1, fmt NONE, imm 0, target 0.
REQ-023 out_target SHALL be computed modulo 2^XLEN; overflow wraps silently.
REQ-024 Input handshake completes when in_valid && in_ready; output handshake completes when out_valid && out_ready.
REQ-025 Latency SHALL be 1 cycle: an entry accepted in cycle N is presented at out_* in cycle N+1 when the buffer is empty.
REQ-026 in_ready SHALL equal (count < DEPTH), combinationally from registered count only; no combinational path from out_ready to in_ready.
REQ-027 DEPTH=2 SHALL sustain 1 entry/cycle under continuous out_ready=1.
REQ-028 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-029 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-030 flush SHALL set count to 0 next cycle and take priority over a same-cycle push, which is dropped.
REQ-031 out_* other than out_valid SHALL be 0 whenever out_valid=0.

Reset
REQ-032 rst_n low SHALL immediately force count=0, out_valid=0, all data outputs 0; in_ready=1 during and after reset.
REQ-033 Reset mid-transfer SHALL discard all entries; no entry SHALL reappear after reset release.

Structure
REQ-034 Shared package imm_pkg SHALL hold the fmt enum, opcode localparams and XLEN legality check.
REQ-035 Combinational decoder SHALL be sub-module imm_decode (inst, pc -> imm, fmt, target, illegal), feeding the buffer in imm_decode_stage.

Verification
REQ-036 XLEN=32, 0xFFF00093 (addi -1) -> cycle+1 out_imm 0xFFFFFFFF, fmt I; 0x4010D093 (srai 1) -> imm 1, fmt SHAMT.
REQ-037 0xFE000EE3 (beq -4), pc 0x100 -> imm 0xFFFFFFFC, target 0x000000FC, fmt B.
REQ-038 0x12345097 (auipc), pc 0x1000 -> imm 0x12345000, target 0x12346000; 0x123450B7 (lui) -> target 0.
REQ-039 out_ready=0, push A,B,C -> in_ready 0 after B, C stalled; release -> A,B,C in order, each held while stalled.
REQ-040 count=2 with flush and in_valid asserted together -> out_valid 0 next cycle, pushed entry absent; 0x00000000 -> illegal=1, imm 0.
REQ-041 XLEN=64, 0xFFFFF06F (jal -2), pc 0x0 -> imm and target 0xFFFFFFFFFFFFFFFE; rst_n pulse mid-stream -> out_valid 0 immediately.
